// File: rtl/phase_sequence_monitor_pkg.sv
// Shared encodings for the phase sequence monitor: light phases, monitor states
// and error codes, plus the legal phase successor.
package phase_sequence_monitor_pkg;

    localparam logic [1:0] PH_0   = 2'b00;
    localparam logic [1:0] PH_1   = 2'b01;
    localparam logic [1:0] PH_2   = 2'b10;
    localparam logic [1:0] PH_BAD = 2'b11;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_TRACK = 2'b01,
        ST_ERROR = 2'b10
    } mon_state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL  = 3'd1;
    localparam logic [2:0] ERR_ORDER    = 3'd2;
    localparam logic [2:0] ERR_EARLY    = 3'd3;
    localparam logic [2:0] ERR_OVERSTAY = 3'd4;
    localparam logic [2:0] ERR_COUNT    = 3'd5;

    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        case (ph)
            PH_0:    next_phase = PH_1;
            PH_1:    next_phase = PH_2;
            default: next_phase = PH_0;
        endcase
    endfunction

endpackage

// File: rtl/phase_sequence_monitor_lut.sv
// Phase to dwell-count mapping: the count the sequencer shows on the first
// tick of each phase. The illegal phase maps to zero.
module phase_dwell_lut
    import phase_sequence_monitor_pkg::*;
#(
    parameter int DWELL_0 = 5,
    parameter int DWELL_1 = 2,
    parameter int DWELL_2 = 4
) (
    input  logic [1:0] phase,
    output logic [3:0] dwell
);

    always_comb begin
        dwell = 4'd0;
        case (phase)
            PH_0:    dwell = 4'(DWELL_0);
            PH_1:    dwell = 4'(DWELL_1);
            PH_2:    dwell = 4'(DWELL_2);
            default: dwell = 4'd0;
        endcase
    end

endmodule

// File: rtl/phase_sequence_monitor.sv
// Passive checker for the sequencer phase/countdown stream: syncs on the first
// 00/DWELL_0 sample, checks order and dwell, counts cycles, latches first error.
module phase_sequence_monitor
    import phase_sequence_monitor_pkg::*;
#(
    parameter int DWELL_0 = 5,
    parameter int DWELL_1 = 2,
    parameter int DWELL_2 = 4,
    parameter int CYC_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [1:0]       phase,
    input  logic [3:0]       count,
    input  logic             err_clr,
    output logic             in_sync,
    output logic             err,
    output logic [2:0]       err_code,
    output logic             phase_done,
    output logic [CYC_W-1:0] cycle_cnt
);

    mon_state_t       state_reg, state_next;
    logic [1:0]       prev_phase_reg, prev_phase_next;
    logic [3:0]       prev_count_reg, prev_count_next;
    logic             err_reg, err_next;
    logic [2:0]       err_code_reg, err_code_next;
    logic             phase_done_reg, phase_done_next;
    logic [CYC_W-1:0] cycle_cnt_reg, cycle_cnt_next;

    logic [3:0] exp_dwell;
    logic [2:0] chk_code;
    logic       new_phase;
    logic       sync_hit;

    phase_dwell_lut #(
        .DWELL_0(DWELL_0),
        .DWELL_1(DWELL_1),
        .DWELL_2(DWELL_2)
    ) u_dwell_lut (
        .phase(phase),
        .dwell(exp_dwell)
    );

    assign new_phase = (phase != prev_phase_reg);
    assign sync_hit  = (phase == PH_0) && (count == 4'(DWELL_0));

    // First failing check wins; the order here is the error priority.
    always_comb begin
        chk_code = ERR_NONE;
        if (phase == PH_BAD)
            chk_code = ERR_ILLEGAL;
        else if (new_phase && (phase != next_phase(prev_phase_reg)))
            chk_code = ERR_ORDER;
        else if (new_phase && (prev_count_reg != 4'd0))
            chk_code = ERR_EARLY;
        else if (!new_phase && (prev_count_reg == 4'd0))
            chk_code = ERR_OVERSTAY;
        else if (new_phase ? (count != exp_dwell)
                           : (count != prev_count_reg - 4'd1))
            chk_code = ERR_COUNT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_SYNC;
            prev_phase_reg <= PH_0;
            prev_count_reg <= 4'd0;
            err_reg        <= 1'b0;
            err_code_reg   <= ERR_NONE;
            phase_done_reg <= 1'b0;
            cycle_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            prev_phase_reg <= prev_phase_next;
            prev_count_reg <= prev_count_next;
            err_reg        <= err_next;
            err_code_reg   <= err_code_next;
            phase_done_reg <= phase_done_next;
            cycle_cnt_reg  <= cycle_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (err_clr) begin
            state_next = ST_SYNC;
        end else begin
            case (state_reg)
                ST_SYNC:  if (tick && sync_hit) state_next = ST_TRACK;
                ST_TRACK: if (tick && chk_code != ERR_NONE) state_next = ST_ERROR;
                ST_ERROR: state_next = ST_ERROR;
                default:  state_next = ST_SYNC;
            endcase
        end
    end

    always_comb begin
        prev_phase_next = prev_phase_reg;
        prev_count_next = prev_count_reg;
        err_next        = err_reg;
        err_code_next   = err_code_reg;
        phase_done_next = 1'b0;
        cycle_cnt_next  = cycle_cnt_reg;
        if (err_clr) begin
            err_next      = 1'b0;
            err_code_next = ERR_NONE;
        end else if (tick) begin
            if (state_reg == ST_SYNC) begin
                if (sync_hit) begin
                    prev_phase_next = phase;
                    prev_count_next = count;
                end
            end else if (state_reg == ST_TRACK) begin
                if (chk_code != ERR_NONE) begin
                    err_next      = 1'b1;
                    err_code_next = chk_code;
                end else begin
                    prev_phase_next = phase;
                    prev_count_next = count;
                    phase_done_next = new_phase;
                    if (prev_phase_reg == PH_2 && phase == PH_0)
                        cycle_cnt_next = cycle_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign in_sync    = (state_reg == ST_TRACK);
    assign err        = err_reg;
    assign err_code   = err_code_reg;
    assign phase_done = phase_done_reg;
    assign cycle_cnt  = cycle_cnt_reg;

endmodule

// File: tb/tb_phase_sequence_monitor.sv
// Directed bench for phase_sequence_monitor with default dwell times 5/2/4.
module tb_phase_sequence_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [1:0] phase;
    logic [3:0] count;
    logic       err_clr;
    logic       in_sync;
    logic       err;
    logic [2:0] err_code;
    logic       phase_done;
    logic [7:0] cycle_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    phase_sequence_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .phase     (phase),
        .count     (count),
        .err_clr   (err_clr),
        .in_sync   (in_sync),
        .err       (err),
        .err_code  (err_code),
        .phase_done(phase_done),
        .cycle_cnt (cycle_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Drive one tick cycle and sample outputs on the following falling edge.
    task automatic do_tick(input logic [1:0] ph, input logic [3:0] cnt);
        @(negedge clk);
        tick = 1'b1; phase = ph; count = cnt;
        @(negedge clk);
        tick = 1'b0;
        if (phase_done) n_done++;
    endtask

    task automatic run_phase(input logic [1:0] ph, input int from);
        for (int c = from; c >= 0; c--) do_tick(ph, 4'(c));
    endtask

    task automatic do_clr(input logic with_tick);
        @(negedge clk);
        err_clr = 1'b1; tick = with_tick; phase = 2'b00; count = 4'd5;
        @(negedge clk);
        err_clr = 1'b0; tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; phase = 2'b00; count = 4'd0; err_clr = 1'b0;
        do_reset();
        check("rst_in_sync", int'(in_sync), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_phase_done", int'(phase_done), 0);
        check("rst_cycle_cnt", int'(cycle_cnt), 0);

        // Legal full cycle
        do_tick(2'b00, 4'd5);
        check("t1_in_sync", int'(in_sync), 1);
        n_done = 0;
        run_phase(2'b00, 4);
        run_phase(2'b01, 2);
        run_phase(2'b10, 4);
        do_tick(2'b00, 4'd5);
        check("t1_done_pulses", n_done, 3);
        check("t1_cycle_cnt", int'(cycle_cnt), 1);
        check("t1_err", int'(err), 0);

        // Order error: 00 -> 10
        run_phase(2'b00, 4);
        do_tick(2'b10, 4'd4);
        check("t3_err", int'(err), 1);
        check("t3_err_code", int'(err_code), 2);
        check("t3_in_sync", int'(in_sync), 0);
        check("t3_phase_done", int'(phase_done), 0);
        do_tick(2'b11, 4'd1);
        do_tick(2'b01, 4'd2);
        check("t3_code_hold", int'(err_code), 2);
        do_clr(1'b0);
        check("clr_err", int'(err), 0);
        check("clr_err_code", int'(err_code), 0);
        check("clr_cycle_kept", int'(cycle_cnt), 1);

        // Mid-stream start is ignored until 00/5
        do_tick(2'b01, 4'd1);
        do_tick(2'b01, 4'd0);
        run_phase(2'b10, 4);
        check("t2_in_sync_pre", int'(in_sync), 0);
        check("t2_err_pre", int'(err), 0);
        do_tick(2'b00, 4'd5);
        check("t2_in_sync", int'(in_sync), 1);

        // Count error: 01 held at 2
        run_phase(2'b00, 4);
        do_tick(2'b01, 4'd2);
        do_tick(2'b01, 4'd2);
        check("t4_err_code", int'(err_code), 5);
        do_clr(1'b1);
        check("t4_clr_err", int'(err), 0);
        check("t4_clr_tick_ignored", int'(in_sync), 0);
        check("t4_clr_phase_done", int'(phase_done), 0);

        // Overstay in 10, then illegal phase
        do_tick(2'b00, 4'd5);
        run_phase(2'b00, 4);
        run_phase(2'b01, 2);
        run_phase(2'b10, 4);
        do_tick(2'b10, 4'd0);
        check("t5_err_code_overstay", int'(err_code), 4);
        do_clr(1'b0);
        do_tick(2'b00, 4'd5);
        do_tick(2'b11, 4'd4);
        check("t5_err_code_illegal", int'(err_code), 1);
        check("t5_err", int'(err), 1);

        // Early exit from 00
        do_clr(1'b0);
        do_tick(2'b00, 4'd5);
        do_tick(2'b01, 4'd2);
        check("t5_err_code_early", int'(err_code), 3);

        // Wrap of the cycle counter after 256 cycles
        do_reset();
        do_tick(2'b00, 4'd5);
        for (int i = 0; i < 256; i++) begin
            run_phase(2'b00, 4);
            run_phase(2'b01, 2);
            run_phase(2'b10, 4);
            do_tick(2'b00, 4'd5);
            if (i == 254) check("t6_cycle_255", int'(cycle_cnt), 255);
        end
        check("t6_cycle_wrap", int'(cycle_cnt), 0);
        check("t6_err", int'(err), 0);

        // Reset mid-phase, then resync at the next 00/5
        do_tick(2'b00, 4'd4);
        do_tick(2'b00, 4'd3);
        do_reset();
        check("t7_in_sync", int'(in_sync), 0);
        check("t7_cycle_cnt", int'(cycle_cnt), 0);
        check("t7_err", int'(err), 0);
        run_phase(2'b00, 2);
        check("t7_still_sync", int'(in_sync), 0);
        run_phase(2'b01, 2);
        run_phase(2'b10, 4);
        do_tick(2'b00, 4'd5);
        check("t7_resync", int'(in_sync), 1);
        check("t7_err_after", int'(err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
